alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Iterative multiply/divide unit beside the multicycle datapath's combinational ALU. Executes MIPS-style MULT/MULTU/DIV/DIVU over several cycles into HI/LO registers, with a start/busy/done handshake for the control FSM. Supports MTHI/MTLO writes. Width-parametrised successor of the single-cycle ALU.

Parameters:
WIDTH, 32, operand width and width of each of HI/LO; must be even and >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are NOP.
A  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
B  in  WIDTH  multiplier / divisor.
busy  out  1  high while an operation is in RUN or FIX.
done  out  1  one-cycle completion pulse.
div_by_zero  out  1  valid with done; set for DIV/DIVU with B==0.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- One clock, clk; reset synchronous active-low on rst_n. rst_n=0 at an edge: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset mid-operation aborts it; HI/LO are cleared and no done is issued.
- States: IDLE, RUN, FIX.
- IDLE: when start=1 with a MULT/DIV op, latch operand magnitudes (absolute values for signed ops) and the result signs, load counter=WIDTH, go to RUN. With MTHI/MTLO, write A into hi/lo at that edge, pulse done next cycle, stay in IDLE. With NOP, ignore start.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle; counter decrements; when it reaches 1 go to FIX. This takes exactly WIDTH cycles.
- FIX: apply sign correction, write hi/lo, go to IDLE with done=1 for exactly one cycle.
- Timing: start accepted at edge N; busy=1 from N+1 through N+WIDTH+1; hi/lo update and done=1 appear at edge N+WIDTH+1... busy drops at that same edge. Total latency is WIDTH+1 cycles.
- start while busy: ignored, no queueing. start in the done cycle: accepted normally, so back-to-back operation is allowed.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
- DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
- Signed overflow (DIV of most-negative by -1): lo = most-negative value, hi = 0, no flag.
- Divide by zero: full latency still applies. hi = A, lo = all ones, div_by_zero=1 with done. div_by_zero clears on the next done.
- hi/lo hold their value at all times except at the completion edge, the MTHI/MTLO edge, and reset.

Optional Feature:
ALU_MULDIV_RADIX4_EN.
- Defined: multiply uses radix-4 steps (two bits per cycle). RUN lasts WIDTH/2 cycles and multiply latency is WIDTH/2+1. Divide is unchanged.
- Undefined: radix-2 multiply, latency WIDTH+1.
- Results are identical in both builds.

Decomposition:
- Package alu_muldiv_pkg holds the op encoding localparams (OP_MULT .. OP_MTLO) and the state encoding (ST_IDLE, ST_RUN, ST_FIX).
- One sub-module, alu_muldiv_step: combinational single iteration. Inputs: accumulator/remainder, operand, mode. Outputs: next partial product or next remainder/quotient bit.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> hi=lo=0, busy=done=0.
- MULT, A=12, B=-9 -> done exactly 33 cycles after start edge; hi=0xFFFFFFFF, lo=0xFFFFFF94.
- MULTU, A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV, A=-13, B=5 -> lo=0xFFFFFFFE, hi=0xFFFFFFFD. DIVU, A=13, B=5 -> lo=2, hi=3.
- DIVU, A=7, B=0 -> div_by_zero=1, hi=7, lo=0xFFFFFFFF. A second start asserted at cycle 5 of the operation is ignored.
- MTHI, A=0x1234 -> hi=0x1234 next edge, done pulses once, busy stays 0. Assert rst_n=0 mid-MULT -> no done, hi=lo=0.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// controller states and the step-datapath mode.
package alu_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// One combinational iteration: shift-add multiply (radix-2, or radix-4 when
// ALU_MULDIV_RADIX4_EN is defined) or one restoring divide step.
module alu_muldiv_step
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_mode_t       mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

`ifdef ALU_MULDIV_RADIX4_EN
    logic [WIDTH+1:0] mul_sum;
`else
    logic [WIDTH:0]   mul_sum;
`endif
    logic [WIDTH+1:0] div_diff;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        acc_nxt  = acc;
        q_nxt    = q;
`ifdef ALU_MULDIV_RADIX4_EN
        // Retire two multiplier bits: add opnd * q[1:0], shift right by two.
        mul_sum  = {2'b00, acc}
                 + ({2'b00, opnd} & {(WIDTH+2){q[0]}})
                 + ({1'b0, opnd, 1'b0} & {(WIDTH+2){q[1]}});
`else
        mul_sum  = {1'b0, acc} + ({1'b0, opnd} & {(WIDTH+1){q[0]}});
`endif
        // Trial subtract of the divisor from the remainder with the next
        // dividend bit shifted in; the top bit is the borrow.
        div_diff = {1'b0, acc, q[WIDTH-1]} - {2'b00, opnd};

        if (mode == STEP_MUL) begin
`ifdef ALU_MULDIV_RADIX4_EN
            acc_nxt = mul_sum[WIDTH+1:2];
            q_nxt   = {mul_sum[1:0], q[WIDTH-1:2]};
`else
            acc_nxt = mul_sum[WIDTH:1];
            q_nxt   = {mul_sum[0], q[WIDTH-1:1]};
`endif
        end else if (!div_diff[WIDTH+1]) begin
            acc_nxt = div_diff[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {acc[WIDTH-2:0], q[WIDTH-1]};
            q_nxt   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO, start/busy/done
// handshake. Define ALU_MULDIV_RADIX4_EN for two multiply bits per cycle.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_load;
    logic [WIDTH-1:0]       acc, q, opnd, acc_step, q_step;
    logic                   is_div, neg_q, neg_r, dz;
    logic                   start_arith, mt_write, signed_op, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0]     prod_fix;

    always_comb begin
        start_arith = (state == ST_IDLE) && start && !op[2];
        mt_write    = (state == ST_IDLE) && start && (op == OP_MTHI || op == OP_MTLO);
        signed_op   = (op == OP_MULT) || (op == OP_DIV);
        op_div      = (op == OP_DIV) || (op == OP_DIVU);
        a_neg       = signed_op && A[WIDTH-1];
        b_neg       = signed_op && B[WIDTH-1];
        a_mag       = a_neg ? -A : A;
        b_mag       = b_neg ? -B : B;
`ifdef ALU_MULDIV_RADIX4_EN
        cnt_load    = op_div ? CNT_W'(WIDTH) : CNT_W'(WIDTH / 2);
`else
        cnt_load    = CNT_W'(WIDTH);
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_arith)         state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(1))    state_nxt = ST_FIX;
            ST_FIX:                           state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode    (is_div ? STEP_DIV : STEP_MUL),
        .acc     (acc),
        .q       (q),
        .opnd    (opnd),
        .acc_nxt (acc_step),
        .q_nxt   (q_step)
    );

    // Sign correction; a zero divisor leaves |A| in acc, so hi = A naturally.
    always_comb begin
        prod_fix = neg_q ? -{acc, q} : {acc, q};
        quo_fix  = dz ? '1 : (neg_q ? -q : q);
        rem_fix  = neg_r ? -acc : acc;
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_arith) begin
                        cnt <= cnt_load;
                    end else if (mt_write) begin
                        if (op == OP_MTHI) hi <= A;
                        else               lo <= A;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                ST_RUN: cnt <= cnt - CNT_W'(1);
                ST_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done        <= 1'b1;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the iteration datapath is left out of reset; it is always loaded
    // on acceptance before use, and only the architectural state is cleared.
    always_ff @(posedge clk) begin
        if (start_arith) begin
            acc    <= '0;
            q      <= op_div ? a_mag : b_mag;
            opnd   <= op_div ? b_mag : a_mag;
            is_div <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= op_div && a_neg;
            dz     <= op_div && (B == '0);
        end else if (state == ST_RUN) begin
            acc <= acc_step;
            q   <= q_step;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv with hand-computed HI/LO,
// latency, handshake and reset expectations.
module tb_alu_muldiv;

    localparam int W = 32;
`ifdef ALU_MULDIV_RADIX4_EN
    localparam int MUL_LAT = W / 2 + 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                           DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one MULT/DIV-class op, wait (bounded) for done, check everything.
    task automatic arith(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dz, input int exp_lat);
        int lat;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, " busy_run"}, W'(busy), W'(1));
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " dbz"}, W'(div_by_zero), W'(exp_dz));
        check({tag, " busy_done"}, W'(busy), W'(0));
    endtask

    task automatic mt(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        @(negedge clk);
        op = o; A = a; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " done"}, W'(done), W'(1));
        check({tag, " busy"}, W'(busy), W'(0));
        @(posedge clk);
        #1;
        check({tag, " done_once"}, W'(done), W'(0));
        check({tag, " busy_after"}, W'(busy), W'(0));
    endtask

    initial begin
        int lat;
        int dn;

        // Reset held for two edges.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst hi", hi, '0);
        check("rst lo", lo, '0);
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst dbz", W'(div_by_zero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Consecutive arith calls start in the done cycle: back-to-back.
        arith("mult_12_m9",   MULT,  32'd12,        -32'sd9,       32'hFFFFFFFF, 32'hFFFFFF94, 1'b0, MUL_LAT);
        arith("multu_max_2",  MULTU, 32'hFFFFFFFF,  32'd2,         32'h00000001, 32'hFFFFFFFE, 1'b0, MUL_LAT);
        arith("div_m13_5",    DIV,   -32'sd13,      32'd5,         32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, DIV_LAT);
        arith("divu_13_5",    DIVU,  32'd13,        32'd5,         32'd3,        32'd2,        1'b0, DIV_LAT);
        arith("div_7_m2",     DIV,   32'd7,         -32'sd2,       32'd1,        32'hFFFFFFFD, 1'b0, DIV_LAT);
        arith("div_ovf",      DIV,   32'h80000000,  32'hFFFFFFFF,  32'd0,        32'h80000000, 1'b0, DIV_LAT);
        arith("mult_m7_m3",   MULT,  -32'sd7,       -32'sd3,       32'd0,        32'd21,       1'b0, MUL_LAT);
        arith("mult_minsq",   MULT,  32'h80000000,  32'h80000000,  32'h40000000, 32'd0,        1'b0, MUL_LAT);
        arith("div_m8_0",     DIV,   -32'sd8,       32'd0,         32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, DIV_LAT);

        // DIVU 7/0 with a second start during RUN that must be ignored.
        @(negedge clk);
        op = DIVU; A = 32'd7; B = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
            if (lat == 5) begin
                op = MULTU; A = 32'd3; B = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("dz latency", W'(lat), W'(DIV_LAT));
        check("dz hi", hi, 32'd7);
        check("dz lo", lo, 32'hFFFFFFFF);
        check("dz flag", W'(div_by_zero), W'(1));
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        check("dz ignored_start_dones", W'(dn), W'(0));
        check("dz idle_busy", W'(busy), W'(0));
        check("dz flag_held", W'(div_by_zero), W'(1));

        arith("divu_clear_dz", DIVU, 32'd13, 32'd5, 32'd3, 32'd2, 1'b0, DIV_LAT);

        mt("mthi", MTHI, 32'h00001234, 32'h00001234, 32'd2);
        mt("mtlo", MTLO, 32'hCAFEF00D, 32'h00001234, 32'hCAFEF00D);

        // NOP op with start: no effect.
        @(negedge clk);
        op = 3'b110; A = 32'h5555AAAA; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("nop done", W'(done), W'(0));
        check("nop busy", W'(busy), W'(0));
        check("nop hi", hi, 32'h00001234);
        check("nop lo", lo, 32'hCAFEF00D);

        // Reset in the middle of a MULT: aborted, no done, HI/LO cleared.
        @(negedge clk);
        op = MULT; A = 32'd100; B = 32'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        check("midrst dones", W'(dn), W'(0));
        check("midrst hi", hi, '0);
        check("midrst lo", lo, '0);
        check("midrst busy", W'(busy), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
